// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// FSM state encoding, owner encoding and the legal read-latency range.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = 4;

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Read-latency down-counter: loads the latency when a transaction is granted,
// counts down while the memory read is in flight and flags when it hits zero.
module mem_arb_lat_cnt
  import mem_arb_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load has priority; decrement saturates at zero so the flag stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between an instruction fetch port
// and a data port. One transaction at a time: IDLE -> ISSUE -> WAIT -> RESP,
// with writes skipping WAIT.
// Optional macro ARB_RR_EN: simultaneous requests alternate using a
// last-served pointer; without it the data port always wins a conflict.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LAT = 2,
  parameter int AW  = 16,
  parameter int DW  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  input  logic          d_re,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_valid,
  output logic [DW-1:0] d_rdata,
  output logic          d_stall,
  output logic [AW-1:0] m_addr,
  output logic          m_re,
  output logic          m_we,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  state_t        state;
  state_t        state_nxt;
  owner_t        owner;
  logic          is_wr;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          d_req;
  logic          grant_any;
  logic          grant_d;
  logic          grant_edge;
  logic          cnt_zero;
  logic          capture;

  assign d_req      = d_re | d_we;
  assign grant_any  = if_req | d_req;
  assign grant_edge = (state == IDLE) && grant_any;
  assign capture    = (state == WAIT) && cnt_zero;

`ifdef ARB_RR_EN
  owner_t last;

  assign grant_d = d_req && (!if_req || (last == OWN_IF));

  // Remember who was served last; reset value makes the first conflict go to data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= OWN_IF;
    end else if (grant_edge) begin
      last <= grant_d ? OWN_D : OWN_IF;
    end
  end
`else
  assign grant_d = d_req;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; requests only matter in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = ISSUE;
      ISSUE:   state_nxt = is_wr ? RESP : WAIT;
      WAIT:    if (cnt_zero) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the granted request at the grant edge and read data when the latency expires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= OWN_IF;
      is_wr      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (grant_edge) begin
        owner   <= grant_d ? OWN_D : OWN_IF;
        is_wr   <= grant_d && d_we;
        addr_q  <= grant_d ? d_addr : if_addr;
        wdata_q <= d_wdata;
      end
      if (capture) begin
        if (owner == OWN_IF) begin
          if_rdata_q <= m_rdata;
        end else begin
          d_rdata_q <= m_rdata;
        end
      end
    end
  end

  // Loaded at grant so it reaches zero in the cycle m_rdata becomes valid.
  mem_arb_lat_cnt #(
    .W(CNT_W)
  ) u_lat_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (grant_edge),
    .dec     ((state == ISSUE) || (state == WAIT)),
    .load_val(CNT_W'(LAT)),
    .zero    (cnt_zero)
  );

  assign m_re     = (state == ISSUE) && !is_wr;
  assign m_we     = (state == ISSUE) && is_wr;
  assign m_addr   = (state == ISSUE) ? addr_q : '0;
  assign m_wdata  = m_we ? wdata_q : '0;

  assign if_valid = (state == RESP) && (owner == OWN_IF);
  assign d_valid  = (state == RESP) && (owner == OWN_D);
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_stall = if_req && !if_valid;
  assign d_stall  = d_req && !d_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: main instance with LAT=2 plus LAT=1 and
// LAT=15 instances for latency boundaries. Honours ARB_RR_EN for arbitration order.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic        if_req, d_re, d_we;
  logic [15:0] if_addr, d_addr, d_wdata;
  logic        if_valid, if_stall, d_valid, d_stall, m_re, m_we;
  logic [15:0] if_rdata, d_rdata, m_addr, m_wdata, m_rdata;

  mem_arbiter #(.LAT(2), .AW(16), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_stall(d_stall),
    .m_addr(m_addr), .m_re(m_re), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  logic        l1_req, l15_req;
  logic [15:0] l_addr;
  logic        l1_valid, l1_stall, l1_dvalid, l1_dstall, l1_mre, l1_mwe;
  logic [15:0] l1_rdata, l1_drdata, l1_maddr, l1_mwdata, l1_mrdata;
  logic        l15_valid, l15_stall, l15_dvalid, l15_dstall, l15_mre, l15_mwe;
  logic [15:0] l15_rdata, l15_drdata, l15_maddr, l15_mwdata, l15_mrdata;

  mem_arbiter #(.LAT(1), .AW(16), .DW(16)) dut_l1 (
    .clk(clk), .rst(rst),
    .if_req(l1_req), .if_addr(l_addr), .if_valid(l1_valid), .if_rdata(l1_rdata), .if_stall(l1_stall),
    .d_re(1'b0), .d_we(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000),
    .d_valid(l1_dvalid), .d_rdata(l1_drdata), .d_stall(l1_dstall),
    .m_addr(l1_maddr), .m_re(l1_mre), .m_we(l1_mwe), .m_wdata(l1_mwdata), .m_rdata(l1_mrdata)
  );

  mem_arbiter #(.LAT(15), .AW(16), .DW(16)) dut_l15 (
    .clk(clk), .rst(rst),
    .if_req(l15_req), .if_addr(l_addr), .if_valid(l15_valid), .if_rdata(l15_rdata), .if_stall(l15_stall),
    .d_re(1'b0), .d_we(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000),
    .d_valid(l15_dvalid), .d_rdata(l15_drdata), .d_stall(l15_dstall),
    .m_addr(l15_maddr), .m_re(l15_mre), .m_we(l15_mwe), .m_wdata(l15_mwdata), .m_rdata(l15_mrdata)
  );

  // Main memory model: word 0x0010 is fixed at 0xA5A5, others writable; read data appears 2 cycles after m_re and is X otherwise.
  logic [15:0] mem [0:1023];
  logic [15:0] pipe2 [0:1];
  always @(posedge clk) begin
    if (m_we) mem[m_addr[9:0]] <= m_wdata;
    pipe2[0] <= m_re ? ((m_addr == 16'h0010) ? 16'hA5A5 : mem[m_addr[9:0]]) : 16'hxxxx;
    pipe2[1] <= pipe2[0];
  end
  assign m_rdata = pipe2[1];

  // LAT=1 memory model returns the inverted address one cycle after m_re.
  logic [15:0] pipe1;
  always @(posedge clk) pipe1 <= l1_mre ? ~l1_maddr : 16'hxxxx;
  assign l1_mrdata = pipe1;

  // LAT=15 memory model returns the inverted address fifteen cycles after m_re.
  logic [15:0] pipe15 [0:14];
  always @(posedge clk) begin
    pipe15[0] <= l15_mre ? ~l15_maddr : 16'hxxxx;
    for (int i = 1; i < 15; i++) pipe15[i] <= pipe15[i-1];
  end
  assign l15_mrdata = pipe15[14];

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int vcount;
    int rcount;
    int lat1;
    int lat15;
    logic [1:0] order [0:2];
    logic [1:0] exp_mid;

    rst = 1'b1; if_req = 1'b0; d_re = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    l1_req = 1'b0; l15_req = 1'b0; l_addr = 16'h0077;
    order[0] = 2'd0; order[1] = 2'd0; order[2] = 2'd0;
`ifdef ARB_RR_EN
    exp_mid = 2'd2;
`else
    exp_mid = 2'd1;
`endif
    tick(); tick();
    check_output("rst_if_valid", if_valid, 0);
    check_output("rst_d_valid", d_valid, 0);
    check_output("rst_m_re", m_re, 0);
    check_output("rst_m_we", m_we, 0);
    check_output("rst_m_addr", m_addr, 0);
    check_output("rst_m_wdata", m_wdata, 0);
    check_output("rst_if_rdata", if_rdata, 0);
    check_output("rst_d_rdata", d_rdata, 0);
    rst = 1'b0;
    tick();

    // Fetch from 0x0010, LAT=2: m_re at R+1, valid at R+4
    $display("[TB] fetch read");
    if_req = 1'b1; if_addr = 16'h0010; #1;
    check_output("fetch_stall_R", if_stall, 1);
    tick();
    check_output("fetch_m_re", m_re, 1);
    check_output("fetch_m_we", m_we, 0);
    check_output("fetch_m_addr", m_addr, 16'h0010);
    tick();
    check_output("fetch_m_re_once", m_re, 0);
    check_output("fetch_m_addr_idle", m_addr, 0);
    tick();
    check_output("fetch_no_early_valid", if_valid, 0);
    check_output("fetch_stall_wait", if_stall, 1);
    tick();
    check_output("fetch_valid", if_valid, 1);
    check_output("fetch_rdata", if_rdata, 16'hA5A5);
    check_output("fetch_d_valid", d_valid, 0);
    check_output("fetch_stall_done", if_stall, 0);
    if_req = 1'b0;
    tick();
    check_output("fetch_valid_pulse", if_valid, 0);
    check_output("fetch_rdata_hold", if_rdata, 16'hA5A5);

    // Data write 0x1234 to 0x0200: m_we at R+1, d_valid at R+2
    $display("[TB] data write");
    d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234; #1;
    check_output("wr_stall_R", d_stall, 1);
    tick();
    check_output("wr_m_we", m_we, 1);
    check_output("wr_m_re", m_re, 0);
    check_output("wr_m_addr", m_addr, 16'h0200);
    check_output("wr_m_wdata", m_wdata, 16'h1234);
    check_output("wr_no_early_valid", d_valid, 0);
    tick();
    check_output("wr_d_valid", d_valid, 1);
    check_output("wr_m_we_once", m_we, 0);
    check_output("wr_stall_done", d_stall, 0);
    d_we = 1'b0; d_wdata = 16'h0000;
    tick();

    // Read back the written word
    $display("[TB] data read back");
    d_re = 1'b1; d_addr = 16'h0200;
    n = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (d_valid) begin n = k; break; end
    end
    check_output("rd_latency", n, 4);
    check_output("rd_rdata", d_rdata, 16'h1234);
    check_output("rd_if_valid", if_valid, 0);
    d_re = 1'b0;
    tick();

    // Fetch dropped right after ISSUE still completes once
    $display("[TB] dropped fetch");
    if_req = 1'b1; if_addr = 16'h0010;
    tick();
    check_output("drop_m_re", m_re, 1);
    if_req = 1'b0;
    vcount = 0; rcount = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (if_valid) vcount++;
      if (m_re) rcount++;
    end
    check_output("drop_valid_count", vcount, 1);
    check_output("drop_no_more_m_re", rcount, 0);
    check_output("drop_rdata", if_rdata, 16'hA5A5);

    // Reset during WAIT
    $display("[TB] reset mid-transaction");
    if_req = 1'b1; if_addr = 16'h0010;
    tick(); tick();
    rst = 1'b1; #1;
    check_output("midrst_if_valid", if_valid, 0);
    check_output("midrst_m_re", m_re, 0);
    check_output("midrst_m_addr", m_addr, 0);
    check_output("midrst_if_rdata", if_rdata, 0);
    check_output("midrst_d_rdata", d_rdata, 0);
    if_req = 1'b0;
    tick();
    rst = 1'b0;
    vcount = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (if_valid || d_valid) vcount++;
    end
    check_output("midrst_no_valid", vcount, 0);

    // Conflict: data first, then fetch
    $display("[TB] conflict");
    if_req = 1'b1; if_addr = 16'h0010; d_re = 1'b1; d_addr = 16'h0200;
    tick();
    check_output("cf_grant_addr", m_addr, 16'h0200);
    check_output("cf_m_re", m_re, 1);
    n = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (d_valid || if_valid) begin n = k; break; end
    end
    check_output("cf_first_latency", n, 3);
    check_output("cf_first_d_valid", d_valid, 1);
    check_output("cf_first_if_valid", if_valid, 0);
    check_output("cf_first_rdata", d_rdata, 16'h1234);
    d_re = 1'b0;
    n = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (if_valid) begin n = k; break; end
    end
    check_output("cf_second_latency", n, 5);
    check_output("cf_second_rdata", if_rdata, 16'hA5A5);
    if_req = 1'b0;
    tick();

    // Three back-to-back conflicts: D,D,D fixed priority or D,IF,D round-robin
    $display("[TB] repeated conflicts");
    if_req = 1'b1; d_re = 1'b1;
    n = 0;
    for (int k = 0; k < 60 && n < 3; k++) begin
      tick();
      if (d_valid) begin order[n] = 2'd1; n++; end
      else if (if_valid) begin order[n] = 2'd2; n++; end
    end
    if_req = 1'b0; d_re = 1'b0;
    check_output("rr_count", n, 3);
    check_output("rr_order0", order[0], 2'd1);
    check_output("rr_order1", order[1], exp_mid);
    check_output("rr_order2", order[2], 2'd1);
    tick(); tick();

    // Latency boundaries: LAT=1 at R+3, LAT=15 at R+17
    $display("[TB] latency boundaries");
    l1_req = 1'b1; l15_req = 1'b1; #1;
    check_output("l1_stall_R", l1_stall, 1);
    check_output("l15_stall_R", l15_stall, 1);
    lat1 = -1; lat15 = -1; vcount = 0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (lat1 < 0) begin
        if (l1_valid) begin lat1 = k; l1_req = 1'b0; end
        else if (!l1_stall) vcount++;
      end
      if (lat15 < 0) begin
        if (l15_valid) begin lat15 = k; l15_req = 1'b0; end
        else if (!l15_stall) vcount++;
      end
    end
    check_output("l1_latency", lat1, 3);
    check_output("l15_latency", lat15, 17);
    check_output("lat_stall_gaps", vcount, 0);
    check_output("l1_rdata", l1_rdata, 16'hFF88);
    check_output("l15_rdata", l15_rdata, 16'hFF88);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
